mycpu_mc_param: RTL and testbench
=================================

# mycpu_mc_param

Parametrised multi-cycle LoongArch32 subset CPU: the next generation of the team's lab multi-cycle core. Executes one instruction at a time through an IF/ID/EX/MEM/WB state machine, adds sub.w, beq and b, sign-extended branch offsets, a ready-handshaked data port for wait-stated memories, and a HALT state for undecoded instructions. It sits between the instruction ROM, the data RAM and the SDU debug unit.

## Interface

Parameters:
- IADDR_W, 10, instruction RAM word-address width
- DADDR_W, 10, data RAM word-address width
- RESET_PC, 32'h1c000000, PC value after reset

Ports:
- clk  in  1  clock; all state changes on posedge
- rstn  in  1  synchronous, active-low reset
- inst_ram_addr  out  IADDR_W  pc[IADDR_W+1:2]
- inst_ram_rdata  in  32  instruction word, combinational read
- data_ram_req  out  1  data access request, high only in MEM
- data_ram_we  out  1  1 = store, 0 = load; valid with req
- data_ram_addr  out  DADDR_W  ALU result[DADDR_W+1:2]
- data_ram_wdata  out  32  store data (rd register value)
- data_ram_rdata  in  32  load data, valid when ready high
- data_ram_ready  in  1  access completes at posedge where req and ready are both high
- pc  out  32  current PC
- ir  out  32  instruction register
- state  out  3  FSM state
- retire  out  1  high during the last cycle of each completing instruction
- halted  out  1  high in HALT
- dbg_raddr  in  5  debug register read index
- dbg_rdata  out  32  GPR[dbg_raddr], combinational; index 0 reads 0

## Operation

- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- IF: IR <= inst_ram_rdata. Next state is ID.
- ID: decode IR. Register operands A=GPR[rj] and B=GPR[rk], or GPR[rd] for st/beq/bne, plus imm are latched. An undecoded instruction goes to HALT; otherwise the next state is EX.
- Decode, by IR fields:
  - add.w [31:15]=0x00020
  - sub.w 0x00022
  - addi.w [31:22]=0x00A
  - ld.w 0x0A2
  - st.w 0x0A6
  - lu12i.w [31:25]=0x0A
  - b [31:26]=0x14
  - beq 0x16
  - bne 0x17
- Immediates:
  - si12 = IR[21:10], sign-extended.
  - lu12i value = {IR[24:5], 12'b0}, with ALU src1 = 0.
  - offs16 = IR[25:10], sign-extended, <<2.
  - offs26 = {IR[9:0], IR[25:10]}, sign-extended, <<2.
  - Branch target = pc + offset. Arithmetic is 32-bit wrap-around.
- EX: ALU result is latched into Y.
  - ALU ops go to WB.
  - ld/st go to MEM.
  - Branches resolve here and go to IF. pc <= target if taken, else pc+4. b is always taken.
- MEM: req is held high with stable addr/we/wdata until ready is sampled high. A load then latches MDR <= data_ram_rdata and goes to WB. A store goes to IF with pc <= pc+4.
- WB: GPR[rd] <= (ld ? MDR : Y), then go to IF with pc <= pc+4. Writes to r0 are discarded.
- retire is high in WB, in MEM on the ready cycle of a store, and in EX for branches.
- HALT: absorbing state. pc and the GPRs are frozen, halted=1, req=0. Only reset leaves it.

## Timing

- Reset values: pc=RESET_PC, state=IF, ir=0, all GPRs=0, req=0, retire=0, halted=0.
- Latency, with zero wait states:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each cycle ready is low in MEM adds 1 cycle.
- Reset asserted mid-MEM: at the next posedge req=0 and state=IF, with no register write.
- A ready that is high outside MEM is ignored.
- Debug read of a register while WB writes that same register returns the old value until the edge.

## Configuration

- MCCPU_PERF_EN defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - instret_cnt increments on each retire.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan

- Sequence:
  - Program: lu12i.w r1,1; addi.w r1,r1,-1; add.w r2,r1,r1; sub.w r3,r2,r1.
  - ready tied high.
  - Required: dbg reads r1=0x00000fff, r2=0x00001ffe, r3=0x00000fff.
  - 16 cycles from reset release to the 4th retire.
- Sequence:
  - Program: st.w r1,r0,8 then ld.w r4,r0,8.
  - ready low for 3 cycles on each access.
  - Required: data_ram_addr=2 with req held steady during the waits; r4=0x00000fff.
  - Store takes 7 cycles, load takes 8.
- Branches, using offset −2 words (PC-relative), pc=0x1c000010:
  - bne with rj≠rd → pc=0x1c000008.
  - beq with rj≠rd → pc=0x1c000014.
  - b with offs26=3 → pc=0x1c00001c.
- addi.w r0,r0,5 → r0 still reads 0; retire still pulses.
- Instruction 0xffffffff:
  - Required: state=7 and halted=1 after ID.
  - pc unchanged for 20 cycles.
  - rstn low for 1 cycle → pc=0x1c000000, state=0.
- MCCPU_PERF_EN, 10 × add.w:
  - Required: instret_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/mycpu_mc_param.sv
// Multi-cycle LoongArch32 subset CPU (IF/ID/EX/MEM/WB + HALT) with a ready-handshaked data port.
// Define MCCPU_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module mycpu_mc_param #(
  parameter int          IADDR_W  = 10,
  parameter int          DADDR_W  = 10,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [IADDR_W-1:0] inst_ram_addr,
  input  logic [31:0]        inst_ram_rdata,
  output logic               data_ram_req,
  output logic               data_ram_we,
  output logic [DADDR_W-1:0] data_ram_addr,
  output logic [31:0]        data_ram_wdata,
  input  logic [31:0]        data_ram_rdata,
  input  logic               data_ram_ready,
  output logic [31:0]        pc,
  output logic [31:0]        ir,
  output logic [2:0]         state,
  output logic               retire,
  output logic               halted,
  input  logic [4:0]         dbg_raddr,
  output logic [31:0]        dbg_rdata
`ifdef MCCPU_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  state_t cur, nxt;

  logic [31:0] gpr [0:31];
  logic [31:0] opa, opb, imm, y, mdr;

  logic [4:0] rd, rj, rk;
  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];

  logic is_add, is_sub, is_addi, is_ld, is_st, is_lu12i, is_b, is_beq, is_bne;
  logic is_branch, valid;
  assign is_add    = (ir[31:15] == 17'h00020);
  assign is_sub    = (ir[31:15] == 17'h00022);
  assign is_addi   = (ir[31:22] == 10'h00A);
  assign is_ld     = (ir[31:22] == 10'h0A2);
  assign is_st     = (ir[31:22] == 10'h0A6);
  assign is_lu12i  = (ir[31:25] == 7'h0A);
  assign is_b      = (ir[31:26] == 6'h14);
  assign is_beq    = (ir[31:26] == 6'h16);
  assign is_bne    = (ir[31:26] == 6'h17);
  assign is_branch = is_b | is_beq | is_bne;
  assign valid     = is_add | is_sub | is_addi | is_ld | is_st | is_lu12i | is_branch;

  logic [31:0] imm_val;
  always_comb begin
    imm_val = {{20{ir[21]}}, ir[21:10]};
    if (is_lu12i)            imm_val = {ir[24:5], 12'b0};
    else if (is_b)           imm_val = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};
    else if (is_beq | is_bne) imm_val = {{14{ir[25]}}, ir[25:10], 2'b00};
  end

  logic [31:0] alu;
  logic        taken;
  always_comb begin
    alu = opa + imm;
    if (is_add)      alu = opa + opb;
    else if (is_sub) alu = opa - opb;
  end
  assign taken = is_b | (is_beq & (opa == opb)) | (is_bne & (opa != opb));

  always_ff @(posedge clk) begin
    if (!rstn) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    case (cur)
      S_IF:  nxt = S_ID;
      S_ID:  nxt = valid ? S_EX : S_HALT;
      S_EX: begin
        if (is_branch) begin
          nxt    = S_IF;
          retire = 1'b1;
        end else if (is_ld | is_st) nxt = S_MEM;
        else                        nxt = S_WB;
      end
      S_MEM: begin
        if (data_ram_ready) begin
          nxt    = is_ld ? S_WB : S_IF;
          retire = is_st;
        end
      end
      S_WB: begin
        nxt    = S_IF;
        retire = 1'b1;
      end
      default: nxt = S_HALT;
    endcase
  end

  // r0 is never written, so its flop stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc  <= RESET_PC;
      ir  <= '0;
      opa <= '0;
      opb <= '0;
      imm <= '0;
      y   <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (cur)
        S_IF: ir <= inst_ram_rdata;
        S_ID: begin
          opa <= is_lu12i ? 32'd0 : gpr[rj];
          opb <= (is_st | is_beq | is_bne) ? gpr[rd] : gpr[rk];
          imm <= imm_val;
        end
        S_EX: begin
          y <= alu;
          if (is_branch) pc <= taken ? pc + imm : pc + 32'd4;
        end
        S_MEM: begin
          if (data_ram_ready) begin
            if (is_ld) mdr <= data_ram_rdata;
            else       pc  <= pc + 32'd4;
          end
        end
        S_WB: begin
          if (rd != 5'd0) gpr[rd] <= is_ld ? mdr : y;
          pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  assign inst_ram_addr  = pc[IADDR_W+1:2];
  assign data_ram_req   = (cur == S_MEM);
  assign data_ram_we    = is_st;
  assign data_ram_addr  = y[DADDR_W+1:2];
  assign data_ram_wdata = opb;
  assign state          = cur;
  assign halted         = (cur == S_HALT);
  assign dbg_rdata      = gpr[dbg_raddr];

`ifdef MCCPU_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cur != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mycpu_mc_param.sv
// Directed self-checking bench for mycpu_mc_param: ALU sequence, wait-stated memory, branches, r0, HALT, reset.
// The perf-counter test is built only when MCCPU_PERF_EN is defined.
module tb_mycpu_mc_param;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  inst_ram_addr;
  logic [31:0] inst_ram_rdata;
  logic        data_ram_req, data_ram_we, data_ram_ready;
  logic [9:0]  data_ram_addr;
  logic [31:0] data_ram_wdata, data_ram_rdata;
  logic [31:0] pc, ir, dbg_rdata;
  logic [2:0]  state;
  logic        retire, halted;
  logic [4:0]  dbg_raddr = 5'd0;
`ifdef MCCPU_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] rom  [0:1023];
  logic [31:0] dmem [0:1023];
  int wait_states = 0;
  int wait_cnt    = 0;

  always #5 clk = ~clk;

  mycpu_mc_param dut (
    .clk(clk), .rstn(rstn),
    .inst_ram_addr(inst_ram_addr), .inst_ram_rdata(inst_ram_rdata),
    .data_ram_req(data_ram_req), .data_ram_we(data_ram_we),
    .data_ram_addr(data_ram_addr), .data_ram_wdata(data_ram_wdata),
    .data_ram_rdata(data_ram_rdata), .data_ram_ready(data_ram_ready),
    .pc(pc), .ir(ir), .state(state), .retire(retire), .halted(halted),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef MCCPU_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  assign inst_ram_rdata = rom[inst_ram_addr];
  assign data_ram_rdata = dmem[data_ram_addr];
  // Zero wait states ties ready high everywhere, including outside MEM.
  assign data_ram_ready = (wait_states == 0) ? 1'b1 : (data_ram_req && wait_cnt >= wait_states);

  always @(posedge clk) begin
    if (data_ram_req && !data_ram_ready) wait_cnt <= wait_cnt + 1;
    else begin
      wait_cnt <= 0;
      if (data_ram_req && data_ram_we) dmem[data_ram_addr] <= data_ram_wdata;
    end
  end

  function automatic logic [31:0] enc_3r(input logic [16:0] op, input logic [4:0] rd, rj, rk);
    return {op, rk, rj, rd};
  endfunction
  function automatic logic [31:0] enc_i12(input logic [9:0] op, input logic [4:0] rd, rj, input logic [11:0] si12);
    return {op, si12, rj, rd};
  endfunction
  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] rj, rd, input logic [15:0] offs);
    return {op, offs, rj, rd};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] offs);
    return {6'h14, offs[15:0], offs[25:16]};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 32'hffffffff;
  endtask

  // lu12i.w r1,1; addi.w r1,r1,-1; add.w r2,r1,r1; sub.w r3,r2,r1
  task automatic load_alu_prog();
    clear_rom();
    rom[0] = {7'h0A, 20'h00001, 5'd1};
    rom[1] = enc_i12(10'h00A, 5'd1, 5'd1, 12'hfff);
    rom[2] = enc_3r(17'h00020, 5'd2, 5'd1, 5'd1);
    rom[3] = enc_3r(17'h00022, 5'd3, 5'd2, 5'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Counts cycles from the current one until the n-th retire is observed.
  task automatic run_retires(input int n, input int limit, output int cyc);
    int r;
    r = 0;
    cyc = 0;
    while (r < n && cyc < limit) begin
      cyc++;
      if (retire) r++;
      if (r < n) begin
        @(posedge clk);
        #1;
      end
    end
    if (r < n) begin
      vectors++;
      errors++;
      $display("[TB] FAIL retire_timeout: got %0d retires, need %0d", r, n);
    end
  endtask

  task automatic test_sequence();
    int cyc, r;
    logic [31:0] exp_r [1:3];
    exp_r[1] = 32'h00000fff;
    exp_r[2] = 32'h00001ffe;
    exp_r[3] = 32'h00000fff;
    load_alu_prog();
    wait_states = 0;
    dbg_raddr = 5'd2;
    do_reset();
    cyc = 0;
    r = 0;
    while (r < 4 && cyc < 40) begin
      cyc++;
      if (retire) begin
        r++;
        if (r == 3) begin
          vectors++;
          if (dbg_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL dbg_old_during_wb: got %h, need 00000000", dbg_rdata);
          end
        end
      end
      if (r < 4) begin
        @(posedge clk);
        #1;
      end
    end
    vectors++;
    if (cyc !== 16) begin
      errors++;
      $display("[TB] FAIL alu_seq_cycles: got %0d, need 16", cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) begin
      dbg_raddr = 5'(i);
      #1;
      vectors++;
      if (dbg_rdata !== exp_r[i]) begin
        errors++;
        $display("[TB] FAIL alu_seq_r%0d: got %h, need %h", i, dbg_rdata, exp_r[i]);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    dbg_raddr = 5'd1;
    #1;
    vectors++;
    if (pc !== RST_PC || state !== 3'd0 || ir !== 32'd0 || data_ram_req !== 1'b0 ||
        retire !== 1'b0 || halted !== 1'b0 || dbg_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: pc=%h st=%0d ir=%h req=%b ret=%b halt=%b r1=%h, need pc=%h st=0 ir=0 req=0 ret=0 halt=0 r1=0",
               pc, state, ir, data_ram_req, retire, halted, dbg_rdata, RST_PC);
    end
    rstn = 1'b1;
  endtask

  task automatic test_memory();
    int cyc, r, reqc;
    int rc [1:4];
    load_alu_prog();
    rom[2] = enc_i12(10'h0A6, 5'd1, 5'd0, 12'd8);
    rom[3] = enc_i12(10'h0A2, 5'd4, 5'd0, 12'd8);
    wait_states = 3;
    do_reset();
    cyc = 0;
    r = 0;
    reqc = 0;
    while (r < 4 && cyc < 80) begin
      cyc++;
      if (data_ram_req) begin
        reqc++;
        vectors++;
        if (data_ram_addr !== 10'd2 || data_ram_we !== (r == 2)) begin
          errors++;
          $display("[TB] FAIL mem_req_stable: addr=%0d we=%b, need addr=2 we=%b", data_ram_addr, data_ram_we, (r == 2));
        end
      end
      if (retire) begin
        r++;
        rc[r] = cyc;
      end
      if (r < 4) begin
        @(posedge clk);
        #1;
      end
    end
    vectors++;
    if (r == 4 && (rc[3] - rc[2] !== 7 || rc[4] - rc[3] !== 8)) begin
      errors++;
      $display("[TB] FAIL mem_latency: store %0d load %0d, need 7 and 8", rc[3] - rc[2], rc[4] - rc[3]);
    end
    vectors++;
    if (reqc !== 8) begin
      errors++;
      $display("[TB] FAIL mem_req_cycles: got %0d, need 8", reqc);
    end
    @(posedge clk);
    #1;
    dbg_raddr = 5'd4;
    #1;
    vectors++;
    if (dbg_rdata !== 32'h00000fff || dmem[2] !== 32'h00000fff) begin
      errors++;
      $display("[TB] FAIL mem_data: r4=%h mem[2]=%h, need 00000fff both", dbg_rdata, dmem[2]);
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_rom();
    rom[0] = enc_i12(10'h0A2, 5'd4, 5'd0, 12'd8);
    wait_states = 3;
    do_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (state !== 3'd3 || data_ram_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_mem_setup: st=%0d req=%b, need st=3 req=1", state, data_ram_req);
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (state !== 3'd0 || data_ram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_mem_reset: st=%0d req=%b, need st=0 req=0", state, data_ram_req);
    end
    dbg_raddr = 5'd4;
    #1;
    vectors++;
    if (dbg_rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_mem_nowrite: r4=%h, need 00000000", dbg_rdata);
    end
    rstn = 1'b1;
  endtask

  task automatic do_branch(input logic [31:0] inst, input logic [31:0] exp_pc, input string name);
    int cyc;
    load_alu_prog();
    rom[4] = inst;
    wait_states = 0;
    do_reset();
    run_retires(5, 40, cyc);
    vectors++;
    if (cyc !== 19) begin
      errors++;
      $display("[TB] FAIL %s_cycles: got %0d, need 19", name, cyc);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (pc !== exp_pc) begin
      errors++;
      $display("[TB] FAIL %s_pc: got %h, need %h", name, pc, exp_pc);
    end
  endtask

  task automatic test_branches();
    do_branch(enc_br(6'h17, 5'd1, 5'd2, 16'hfffe), 32'h1c000008, "bne_taken");
    do_branch(enc_br(6'h16, 5'd1, 5'd2, 16'hfffe), 32'h1c000014, "beq_not_taken");
    do_branch(enc_b(26'd3), 32'h1c00001c, "b_fwd");
  endtask

  task automatic test_r0();
    int cyc;
    clear_rom();
    rom[0] = enc_i12(10'h00A, 5'd0, 5'd0, 12'd5);
    wait_states = 0;
    do_reset();
    run_retires(1, 10, cyc);
    vectors++;
    if (cyc !== 4) begin
      errors++;
      $display("[TB] FAIL r0_retire_cycle: got %0d, need 4", cyc);
    end
    @(posedge clk);
    #1;
    dbg_raddr = 5'd0;
    #1;
    vectors++;
    if (dbg_rdata !== 32'd0 || pc !== 32'h1c000004) begin
      errors++;
      $display("[TB] FAIL r0_discard: r0=%h pc=%h, need 00000000 1c000004", dbg_rdata, pc);
    end
  endtask

  task automatic test_halt();
    int cyc;
    clear_rom();
    rom[0] = enc_i12(10'h00A, 5'd0, 5'd0, 12'd0);
    wait_states = 0;
    do_reset();
    run_retires(1, 10, cyc);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (state !== 3'd7 || halted !== 1'b1 || pc !== 32'h1c000004) begin
      errors++;
      $display("[TB] FAIL halt_entry: st=%0d halted=%b pc=%h, need 7 1 1c000004", state, halted, pc);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (pc !== 32'h1c000004 || state !== 3'd7 || data_ram_req !== 1'b0 || retire !== 1'b0) begin
        errors++;
        $display("[TB] FAIL halt_frozen: cycle %0d pc=%h st=%0d req=%b ret=%b", i, pc, state, data_ram_req, retire);
      end
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    vectors++;
    if (pc !== RST_PC || state !== 3'd0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_exit_reset: pc=%h st=%0d halted=%b, need %h 0 0", pc, state, halted, RST_PC);
    end
  endtask

`ifdef MCCPU_PERF_EN
  task automatic test_perf();
    int cyc;
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = enc_3r(17'h00020, 5'd2, 5'd1, 5'd1);
    wait_states = 0;
    do_reset();
    run_retires(10, 60, cyc);
    @(posedge clk);
    #1;
    vectors++;
    if (instret_cnt !== 32'd10 || cycle_cnt !== 32'd40) begin
      errors++;
      $display("[TB] FAIL perf_counters: instret=%0d cycles=%0d, need 10 40", instret_cnt, cycle_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = 32'd0;
    test_sequence();
    test_reset();
    test_memory();
    test_reset_mid_mem();
    test_branches();
    test_r0();
    test_halt();
`ifdef MCCPU_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
